// File: rtl/clint_timer.sv
// Machine timer / software-interrupt unit: mtime, mtimecmp and msip behind a
// single-outstanding request/response port, with mtime advancing at 1 MHz.
module clint_timer #(
  parameter int unsigned FMAX_MHz = 27
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [4:0]  req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic [63:0] reg_mtime,
  output logic [63:0] reg_mtimecmp,
  output logic        mtip,
  output logic        msip
);

  localparam int unsigned     PW      = (FMAX_MHz > 1) ? $clog2(FMAX_MHz) : 1;
  localparam logic [PW-1:0]   PRE_MAX = PW'(FMAX_MHz - 1);

  typedef enum logic {IDLE, RESP} state_e;

  state_e        state_q, state_d;
  logic [PW-1:0] pre_q, pre_d;
  logic [63:0]   mtime_q, mtime_d;
  logic [63:0]   mtimecmp_q, mtimecmp_d;
  logic          msip_q, msip_d;
  logic          mtip_q;
  logic          resp_valid_q;
  logic [31:0]   rdata_q, rdata_d;

  logic          tick;
  logic          accept;
  logic [2:0]    word;
  logic          unused_addr;

  assign tick        = (pre_q == PRE_MAX);
  assign pre_d       = tick ? '0 : pre_q + PW'(1);
  assign accept      = (state_q == IDLE) && req_valid;
  assign word        = req_addr[4:2];
  assign unused_addr = ^req_addr[1:0];

  // NOTE: every variable gets a default at the top of the block, so no path
  // through the case statements can leave it unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    mtime_d    = mtime_q + {63'd0, tick};
    mtimecmp_d = mtimecmp_q;
    msip_d     = msip_q;
    rdata_d    = '0;

    case (state_q)
      IDLE:    if (req_valid) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // A write to one mtime half overrides only that half of the ticked value,
    // so a carry out of the low half still lands in the high half.
    if (accept && req_write) begin
      case (word)
        3'd0: mtime_d[31:0]     = req_wdata;
        3'd1: mtime_d[63:32]    = req_wdata;
        3'd2: mtimecmp_d[31:0]  = req_wdata;
        3'd3: mtimecmp_d[63:32] = req_wdata;
        3'd4: msip_d            = req_wdata[0];
        default: ;
      endcase
    end else if (accept) begin
      case (word)
        3'd0: rdata_d = mtime_q[31:0];
        3'd1: rdata_d = mtime_q[63:32];
        3'd2: rdata_d = mtimecmp_q[31:0];
        3'd3: rdata_d = mtimecmp_q[63:32];
        3'd4: rdata_d = {31'd0, msip_q};
        default: rdata_d = '0;
      endcase
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      pre_q        <= '0;
      mtime_q      <= '0;
      mtimecmp_q   <= '1;
      msip_q       <= 1'b0;
      mtip_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      rdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      pre_q        <= pre_d;
      mtime_q      <= mtime_d;
      mtimecmp_q   <= mtimecmp_d;
      msip_q       <= msip_d;
      mtip_q       <= (mtime_q >= mtimecmp_q);
      resp_valid_q <= accept;
      rdata_q      <= rdata_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = resp_valid_q;
  assign resp_rdata   = rdata_q;
  assign reg_mtime    = mtime_q;
  assign reg_mtimecmp = mtimecmp_q;
  assign mtip         = mtip_q;
  assign msip         = msip_q;

endmodule
